// File: rtl/processor_pkg.sv
// Shared front-end types and constants for the instruction fetch path.
package processor_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = '0;
  localparam logic [WORD_W-1:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Prefetch FIFO with flush; pointers carry one extra wrap bit.
module fetch_queue #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count = wptr_q - rptr_q;
  assign rdata = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[wptr_q[AW-1:0]] = wdata;
        wptr_d = wptr_q + ONE;
      end
      if (pop && !empty) begin
        rptr_d = rptr_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC counter, RAM read credit and redirect squash.
// Define IFU_BYPASS_EN to forward returning words past an empty queue.
module instruction_fetch_unit #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = processor_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC =
    ADDR_W'(processor_pkg::RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_rw,
  input  logic [31:0]       mem_dout,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc
);

  import processor_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_C = (AW+2)'(DEPTH);

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;

  logic              issue;
  logic              byp;
  logic [AW+1:0]     credit;
  logic [AW:0]       q_count;
  logic              q_full, q_empty;
  logic              q_push, q_pop;
  entry_t            q_head, push_entry;

  assign mem_a  = fetch_pc_q;
  assign mem_rw = 1'b0;
  assign credit = {1'b0, q_count} + {{(AW+1){1'b0}}, inflight_q};

  // Credit counts the in-flight read so a return can never hit a full queue
  always_comb begin
    issue         = !redirect_valid && !q_full && (credit < DEPTH_C);
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_comb begin
`ifdef IFU_BYPASS_EN
    byp = inflight_q && q_empty;
`else
    byp = 1'b0;
`endif
    push_entry = '{word: mem_dout, pc: inflight_pc_q};
    inst_valid = byp || !q_empty;
    inst       = byp ? mem_dout      : q_head.word;
    inst_pc    = byp ? inflight_pc_q : q_head.pc;
    q_push     = inflight_q && !(byp && inst_ready);
    q_pop      = !byp && !q_empty && inst_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (q_push),
    .wdata (push_entry),
    .pop   (q_pop),
    .rdata (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

endmodule
